// File: rtl/bitmap_encoder_pkg.sv
// Shared types and constants for bitmap_encoder: FSM state enum, default
// widths and the one-hot mask helper used to retire emitted bits.
package bitmap_encoder_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_IDX_W = $clog2(DEF_WIDTH);
  localparam int MASK_W    = 64;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // One-hot mask for a bit index; callers slice down to their own width.
  function automatic logic [MASK_W-1:0] idx_mask(input int unsigned idx);
    return MASK_W'(1) << idx;
  endfunction

endpackage

// File: rtl/bitmap_encoder_bit_find.sv
// Combinational first-set-bit finder. Lowest set bit wins by default;
// highest set bit wins when BITMAP_ENCODER_MSB_FIRST_EN is defined.
module bit_find
  import bitmap_encoder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    any = |vec;
`ifdef BITMAP_ENCODER_MSB_FIRST_EN
    for (int i = 0; i < WIDTH; i++)
      if (vec[i]) idx = IDX_W'(i);
`else
    for (int i = WIDTH - 1; i >= 0; i--)
      if (vec[i]) idx = IDX_W'(i);
`endif
  end

endmodule

// File: rtl/bitmap_encoder.sv
// Sequential bitmap-to-index encoder: accepts a bitmap, emits one index per
// set bit with last/zero flags. Scan direction set by BITMAP_ENCODER_MSB_FIRST_EN.
module bitmap_encoder
  import bitmap_encoder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDX_W-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             out_zero
);

  state_t           state;
  logic [WIDTH-1:0] pending;
  logic             zero_flag;

  logic [IDX_W-1:0]  find_idx;
  logic              find_any;
  logic              single;
  logic              scanning;
  logic [MASK_W-1:0] mask_full;
  logic [WIDTH-1:0]  emit_mask;

  bit_find #(
    .WIDTH(WIDTH),
    .IDX_W(IDX_W)
  ) u_find (
    .vec(pending),
    .idx(find_idx),
    .any(find_any)
  );

  // Exactly one bit left: nonzero and clearing its lowest set bit leaves zero.
  assign single    = find_any && ((pending & (pending - WIDTH'(1))) == '0);
  assign scanning  = (state == SCAN);
  assign mask_full = idx_mask(32'(find_idx));
  assign emit_mask = mask_full[WIDTH-1:0];

  assign in_ready  = enable && (state == IDLE);
  assign out_valid = enable && scanning;
  assign out       = (scanning && !zero_flag) ? find_idx : '0;
  assign out_last  = scanning && (single || zero_flag);
  assign out_zero  = zero_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending   <= '0;
      zero_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            pending   <= in;
            zero_flag <= (in == '0);
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (out_valid && out_ready) begin
            pending <= pending & ~emit_mask;
            if (out_last) begin
              state     <= IDLE;
              zero_flag <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitmap_encoder.sv
// Self-checking bench for bitmap_encoder: hand table, corner-case sequences
// and random bitmaps against a queue-based reference model.
module tb_bitmap_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] in_bm = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] out_idx;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_last;
  logic       out_zero;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  bit exp_zero;

  always #5 clk = ~clk;

  bitmap_encoder #(.WIDTH(8), .IDX_W(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .in(in_bm),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out(out_idx),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .out_zero(out_zero)
  );

  typedef struct {
    logic [7:0] bm;
    int         beats;
    int         first;
    int         final_idx;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: list of set-bit positions in emission order; zero map -> single index 0.
  function automatic void model_load(input logic [7:0] bm);
    exp_q.delete();
    exp_zero = (bm == 8'h00);
    if (bm == 8'h00) exp_q.push_back(0);
    for (int i = 0; i < 8; i++) begin
      if (bm[i]) begin
`ifdef BITMAP_ENCODER_MSB_FIRST_EN
        exp_q.push_front(i);
`else
        exp_q.push_back(i);
`endif
      end
    end
  endfunction

  // Accept a bitmap; ends on the negedge one cycle after the accepting edge.
  task automatic send(input logic [7:0] bm);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("accept_ready", in_ready, 1);
    in_bm    = bm;
    in_valid = 1'b1;
    model_load(bm);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_bm    = 8'($urandom);
    @(negedge clk);
    check("latency_valid", out_valid, 1);
  endtask

  // Consume up to nbeats beats, comparing each cycle against the model head.
  task automatic drain(input int nbeats, input bit rnd, output int got, output int last_idx);
    int  t = 0;
    bit  hs;
    got = 0;
    last_idx = -1;
    while (got < nbeats && exp_q.size() > 0 && t < 300) begin
      out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      check("out_valid", out_valid, 1);
      check("out_idx", out_idx, exp_q[0]);
      check("out_last", out_last, exp_q.size() == 1);
      check("out_zero", out_zero, exp_zero);
      hs = out_ready && out_valid;
      if (hs && out_last) last_idx = int'(out_idx);
      @(posedge clk);
      if (hs) begin
        void'(exp_q.pop_front());
        got++;
      end
      @(negedge clk);
      t++;
    end
    check("drain_bound", (t < 300), 1);
    if (exp_q.size() == 0) begin
      check("idle_in_ready", in_ready, 1);
      check("idle_out_valid", out_valid, 0);
    end
  endtask

  initial begin
    int got, last_idx;

    tbl[0] = '{8'hA4, 3, 2, 7};
    tbl[1] = '{8'h00, 1, 0, 0};
    tbl[2] = '{8'h81, 2, 0, 7};
    tbl[3] = '{8'hFF, 8, 0, 7};
    tbl[4] = '{8'h01, 1, 0, 0};
    tbl[5] = '{8'h80, 1, 7, 7};
    tbl[6] = '{8'h5A, 4, 1, 6};

    // Reset state
    enable = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out_idx, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_zero", out_zero, 0);
    rst_n = 1'b1;

    // Table-driven bitmaps
    for (int k = 0; k < 7; k++) begin
      int f, l;
      f = tbl[k].first;
      l = tbl[k].final_idx;
`ifdef BITMAP_ENCODER_MSB_FIRST_EN
      f = tbl[k].final_idx;
      l = tbl[k].first;
`endif
      send(tbl[k].bm);
      check("tbl_first", out_idx, f);
      check("tbl_zero", out_zero, tbl[k].bm == 8'h00);
      drain(8, 1'b0, got, last_idx);
      check("tbl_beats", got, tbl[k].beats);
      check("tbl_final", last_idx, l);
    end

    // Backpressure: payload held while out_ready low
    send(8'h81);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", out_valid, 1);
`ifdef BITMAP_ENCODER_MSB_FIRST_EN
      check("bp_out", out_idx, 7);
`else
      check("bp_out", out_idx, 0);
`endif
      check("bp_last", out_last, 0);
      @(negedge clk);
    end
    drain(2, 1'b0, got, last_idx);
    check("bp_beats", got, 2);

    // Enable stall mid-scan
    send(8'hFF);
    drain(3, 1'b0, got, last_idx);
    enable = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("stall_valid", out_valid, 0);
      check("stall_in_ready", in_ready, 0);
      check("stall_hold", out_idx, exp_q[0]);
      @(negedge clk);
    end
    enable = 1'b1;
    #1;
    drain(8, 1'b0, got, last_idx);
    check("stall_resume_beats", got, 5);

    // Asynchronous reset during scan
    send(8'hF0);
    drain(1, 1'b0, got, last_idx);
    rst_n = 1'b0;
    #1;
    check("mrst_valid", out_valid, 0);
    check("mrst_out", out_idx, 0);
    check("mrst_last", out_last, 0);
    check("mrst_zero", out_zero, 0);
    check("mrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_no_beat", out_valid, 0);
    send(8'h02);
    drain(8, 1'b0, got, last_idx);
    check("mrst_new_beats", got, 1);
    check("mrst_new_idx", last_idx, 1);

    // Random bitmaps with random backpressure
    for (int r = 0; r < 40; r++) begin
      send(8'($urandom));
      drain(8, 1'b1, got, last_idx);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
